// File: rtl/bil_win_gen.sv
// Raster-to-window generator for the bilateral conv stage; each window leaves 2 cycles after its completing pixel.
// No backpressure: i_pxl_vld gaps freeze all state. Define BIL_WIN_STAT_EN to add the o_win_cnt output.
module bil_win_gen #(
  parameter int CIW       = 8,
  parameter int KRNV_SZ   = 5,
  parameter int ODATA_RNG = 5,
  parameter int HSZ_MAX   = 1920,
  parameter int HSZ_WTH   = 11,
  parameter int VSZ_WTH   = 11
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_pxl_vld,
  input  logic [CIW-1:0]                   i_pxl_data,
  input  logic                             i_sof,
  input  logic [HSZ_WTH-1:0]               i_hsize,
  input  logic [VSZ_WTH-1:0]               i_vsize,
  output logic [CIW*KRNV_SZ*ODATA_RNG-1:0] o_data,
  output logic                             o_vld,
  output logic                             o_sof,
  output logic                             o_eol,
`ifdef BIL_WIN_STAT_EN
  output logic [HSZ_WTH+VSZ_WTH-1:0]       o_win_cnt,
`endif
  output logic                             o_eof
);

  localparam int COLW = CIW * KRNV_SZ;
  localparam int NLB  = KRNV_SZ - 1;
  localparam int SHW  = COLW * (ODATA_RNG - 1);
  localparam logic [HSZ_WTH-1:0] H_ONE    = HSZ_WTH'(1);
  localparam logic [HSZ_WTH-1:0] WIN_COL0 = HSZ_WTH'(ODATA_RNG - 1);
  localparam logic [VSZ_WTH-1:0] V_ONE    = VSZ_WTH'(1);
  localparam logic [VSZ_WTH-1:0] WIN_ROW0 = VSZ_WTH'(KRNV_SZ - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [HSZ_WTH-1:0]   col_cnt, col_nxt, hsize_r, hsize_nxt, h_cur, pos_col;
  logic [VSZ_WTH-1:0]   row_cnt, row_nxt, vsize_r, vsize_nxt, v_cur, pos_row;
  logic                 start, acc, kill, eol, last, win;

  logic                 s1_acc, s1_win, s1_sof, s1_eol, s1_eof;
  logic [CIW-1:0]       s1_pix;
  logic [HSZ_WTH-1:0]   s1_col;
  logic [CIW-1:0]       rd [NLB];
  logic [CIW-1:0]       lb [NLB][HSZ_MAX];
  logic [COLW-1:0]      new_col;
  logic [SHW-1:0]       win_sh;
  logic                 fire;

  // An i_sof pixel is always position (0,0) of a fresh frame, whatever the counters hold.
  always_comb begin
    start     = i_pxl_vld & i_sof;
    acc       = start | (i_pxl_vld & (state == FILL || state == RUN));
    kill      = start & (state == FILL || state == RUN);
    h_cur     = start ? i_hsize : hsize_r;
    v_cur     = start ? i_vsize : vsize_r;
    pos_col   = start ? '0 : col_cnt;
    pos_row   = start ? '0 : row_cnt;
    eol       = (pos_col == h_cur - H_ONE);
    last      = eol && (pos_row == v_cur - V_ONE);
    win       = (pos_row >= WIN_ROW0) && (pos_col >= WIN_COL0);
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    hsize_nxt = hsize_r;
    vsize_nxt = vsize_r;
    if (acc) begin
      hsize_nxt = h_cur;
      vsize_nxt = v_cur;
      col_nxt   = eol ? '0 : pos_col + H_ONE;
      row_nxt   = eol ? pos_row + V_ONE : pos_row;
      if (last)
        state_nxt = DONE;
      else if (row_nxt >= WIN_ROW0)
        state_nxt = RUN;
      else
        state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      hsize_r <= '0;
      vsize_r <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      hsize_r <= hsize_nxt;
      vsize_r <= vsize_nxt;
    end
  end

  // Line buffers: read at acceptance, cascade write one cycle later at the same column.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int k = 0; k < NLB; k++)
        rd[k] <= lb[k][pos_col];
    end
    if (s1_acc) begin
      lb[0][s1_col] <= s1_pix;
      for (int k = 1; k < NLB; k++)
        lb[k][s1_col] <= rd[k-1];
    end
  end

  // Newest line sits in the top row of the column.
  always_comb begin
    new_col = '0;
    new_col[(KRNV_SZ-1)*CIW +: CIW] = s1_pix;
    for (int j = 0; j < KRNV_SZ - 1; j++)
      new_col[j*CIW +: CIW] = rd[KRNV_SZ-2-j];
    fire = s1_acc & s1_win & ~kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc <= 1'b0;
      s1_win <= 1'b0;
      s1_sof <= 1'b0;
      s1_eol <= 1'b0;
      s1_eof <= 1'b0;
      s1_pix <= '0;
      s1_col <= '0;
      win_sh <= '0;
      o_data <= '0;
      o_vld  <= 1'b0;
      o_sof  <= 1'b0;
      o_eol  <= 1'b0;
      o_eof  <= 1'b0;
    end else begin
      s1_acc <= acc;
      if (acc) begin
        s1_win <= win;
        s1_sof <= win && (pos_row == WIN_ROW0) && (pos_col == WIN_COL0);
        s1_eol <= eol;
        s1_eof <= last;
        s1_pix <= i_pxl_data;
        s1_col <= pos_col;
      end
      if (s1_acc)
        win_sh <= {new_col, win_sh[SHW-1:COLW]};
      if (fire)
        o_data <= {new_col, win_sh};
      o_vld <= fire;
      o_sof <= fire & s1_sof;
      o_eol <= fire & s1_eol;
      o_eof <= fire & s1_eof;
    end
  end

`ifdef BIL_WIN_STAT_EN
  localparam logic [HSZ_WTH+VSZ_WTH-1:0] CNT_ONE = (HSZ_WTH + VSZ_WTH)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_win_cnt <= '0;
    else if (start)
      o_win_cnt <= '0;
    else if (fire)
      o_win_cnt <= o_win_cnt + CNT_ONE;
  end
`endif

endmodule

// File: tb/tb_bil_win_gen.sv
// Self-checking bench for bil_win_gen: randomized rasters checked against an image-based window model.
module tb_bil_win_gen;
  localparam int CIW = 8;
  localparam int K   = 3;
  localparam int O   = 3;
  localparam int HW  = 11;
  localparam int VW  = 11;
  localparam int W   = CIW * K * O;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eol;
    logic         eof;
    logic [31:0]  cyc;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_pxl_vld = 1'b0;
  logic [CIW-1:0] i_pxl_data = '0;
  logic          i_sof = 1'b0;
  logic [HW-1:0] i_hsize = HW'(6);
  logic [VW-1:0] i_vsize = VW'(4);
  logic [W-1:0]  o_data;
  logic          o_vld, o_sof, o_eol, o_eof;
`ifdef BIL_WIN_STAT_EN
  logic [HW+VW-1:0] o_win_cnt;
`endif

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  win_t mon_q[$];
  win_t exp_q[$];
  logic [CIW-1:0] img [16][16];
  int   pcyc [16][16];

  bil_win_gen #(
    .CIW(CIW), .KRNV_SZ(K), .ODATA_RNG(O), .HSZ_MAX(1920), .HSZ_WTH(HW), .VSZ_WTH(VW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_pxl_vld(i_pxl_vld), .i_pxl_data(i_pxl_data),
    .i_sof(i_sof), .i_hsize(i_hsize), .i_vsize(i_vsize), .o_data(o_data),
    .o_vld(o_vld), .o_sof(o_sof), .o_eol(o_eol),
`ifdef BIL_WIN_STAT_EN
    .o_win_cnt(o_win_cnt),
`endif
    .o_eof(o_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin : mon
    win_t w;
    if (o_vld === 1'b1) begin
      w.data = o_data; w.sof = o_sof; w.eol = o_eol; w.eof = o_eof; w.cyc = cyc;
      mon_q.push_back(w);
    end
  end

  task automatic idle(input int n);
    @(negedge clk);
    i_pxl_vld = 1'b0;
    i_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives a raster (optionally cut before pixel index stop_idx) and appends the windows it must produce.
  task automatic drive_frame(input int h, input int v, input int gmax, input int stop_idx,
                             input int base, input bit rnd);
    int lim;
    win_t w;
    lim = (stop_idx < 0) ? h * v : stop_idx;
    for (int idx = 0; idx < lim; idx++) begin
      int r, c;
      r = idx / h;
      c = idx % h;
      img[r][c] = rnd ? CIW'($urandom) : CIW'(r * 16 + c + base);
      if (idx > 0) begin
        repeat ($urandom_range(gmax, 0)) begin
          @(negedge clk);
          i_pxl_vld = 1'b0; i_sof = 1'b0; i_pxl_data = CIW'($urandom);
        end
      end
      @(negedge clk);
      i_pxl_vld = 1'b1; i_sof = (idx == 0); i_pxl_data = img[r][c];
      i_hsize = HW'(h); i_vsize = VW'(v);
      pcyc[r][c] = cyc;
    end
    for (int idx = 0; idx < lim; idx++) begin
      int r, c;
      r = idx / h;
      c = idx % h;
      if (r >= K - 1 && c >= O - 1) begin
        w.data = '0;
        for (int i = 0; i < O; i++)
          for (int j = 0; j < K; j++)
            w.data[(i*K+j)*CIW +: CIW] = img[r-K+1+j][c-O+1+i];
        w.sof = (r == K - 1) && (c == O - 1);
        w.eol = (c == h - 1);
        w.eof = w.eol && (r == v - 1);
        w.cyc = pcyc[r][c] + 2;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (o_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", o_vld); else n_pass++;
    n_chk++; if (o_data !== '0) $display("FAIL reset_data: got %h want 0", o_data); else n_pass++;
    n_chk++; if ({o_sof, o_eol, o_eof} !== 3'b000) $display("FAIL reset_markers: got %b want 000", {o_sof, o_eol, o_eof}); else n_pass++;
`ifdef BIL_WIN_STAT_EN
    n_chk++; if (o_win_cnt !== '0) $display("FAIL reset_win_cnt: got %0d want 0", o_win_cnt); else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [7:0] sv, ev, fv;
    idle(2); mon_q.delete(); exp_q.delete();
    drive_frame(6, 4, 0, -1, 0, 0);
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL full_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL full_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
    if (mon_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        sv[i] = mon_q[i].sof; ev[i] = mon_q[i].eol; fv[i] = mon_q[i].eof;
      end
      n_chk++; if (mon_q[0].data[0 +: 24] !== 24'h201000) $display("FAIL full_first_col0: got %h want 201000", mon_q[0].data[0 +: 24]); else n_pass++;
      n_chk++; if (mon_q[0].data[48 +: 24] !== 24'h221202) $display("FAIL full_first_col2: got %h want 221202", mon_q[0].data[48 +: 24]); else n_pass++;
      n_chk++; if (mon_q[7].data[48 +: 24] !== 24'h352515) $display("FAIL full_last_col2: got %h want 352515", mon_q[7].data[48 +: 24]); else n_pass++;
      n_chk++; if ({sv, ev, fv} !== {8'b0000_0001, 8'b1000_1000, 8'b1000_0000}) $display("FAIL full_markers: got sof=%b eol=%b eof=%b", sv, ev, fv); else n_pass++;
    end else begin
      n_chk++; $display("FAIL full_pattern: got %0d windows want 8", mon_q.size());
    end
`ifdef BIL_WIN_STAT_EN
    n_chk++; if (o_win_cnt !== (HW+VW)'(8)) $display("FAIL stat_final: got %0d want 8", o_win_cnt); else n_pass++;
    idle(3);
    n_chk++; if (o_win_cnt !== (HW+VW)'(8)) $display("FAIL stat_hold: got %0d want 8", o_win_cnt); else n_pass++;
    i_pxl_vld = 1'b1; i_sof = 1'b1; i_pxl_data = '0;
    @(negedge clk);
    i_pxl_vld = 1'b0; i_sof = 1'b0;
    n_chk++; if (o_win_cnt !== '0) $display("FAIL stat_clear: got %0d want 0", o_win_cnt); else n_pass++;
`endif
  endtask

  task automatic test_gaps();
    idle(2); mon_q.delete(); exp_q.delete();
    drive_frame(6, 4, 3, -1, 0, 0);
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL gaps_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL gaps_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int n1, s;
    win_t keep[$];
    idle(2); mon_q.delete(); exp_q.delete();
    drive_frame(6, 4, 0, 3 * 6 + 3, 8'h40, 0);
    n1 = exp_q.size();
    drive_frame(6, 4, 0, -1, 0, 0);
    s = pcyc[0][0];
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= n1 || exp_q[i].cyc <= 32'(s)) keep.push_back(exp_q[i]);
    exp_q = keep;
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL abort_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL abort_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    win_t keep[$];
    idle(2); mon_q.delete(); exp_q.delete();
    drive_frame(6, 4, 0, 2 * 6 + 4, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; rc = cyc; i_sof = 1'b1;
    #1;
    n_chk++; if ({o_vld, o_sof, o_eol, o_eof} !== 4'b0000) $display("FAIL rstmid_flags: got %b want 0000", {o_vld, o_sof, o_eol, o_eof}); else n_pass++;
    n_chk++; if (o_data !== '0) $display("FAIL rstmid_data: got %h want 0", o_data); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (o_vld !== 1'b0) $display("FAIL rstmid_vld: got %b want 0", o_vld); else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1; i_pxl_vld = 1'b0; i_sof = 1'b0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].cyc < 32'(rc)) keep.push_back(exp_q[i]);
    exp_q = keep;
    drive_frame(6, 4, 0, -1, 0, 0);
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL rstmid_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_degenerate();
    idle(2); mon_q.delete(); exp_q.delete();
    drive_frame(2, 4, 1, -1, 0, 1);
    idle(3);
    repeat (8) begin
      @(negedge clk);
      i_pxl_vld = 1'b1; i_sof = 1'b0; i_pxl_data = CIW'($urandom);
    end
    idle(3);
    drive_frame(6, 2, 0, -1, 0, 1);
    repeat (8) begin
      @(negedge clk);
      i_pxl_vld = 1'b1; i_sof = 1'b0; i_pxl_data = CIW'($urandom);
    end
    idle(4);
    n_chk++; if (mon_q.size() !== 0) $display("FAIL degen_none: got %0d windows want 0", mon_q.size()); else n_pass++;
    drive_frame(4, 3, 0, -1, 0, 1);
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL degen_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL degen_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    idle(2); mon_q.delete(); exp_q.delete();
    for (int f = 0; f < 4; f++)
      drive_frame($urandom_range(8, 3), $urandom_range(6, 3), 2, -1, 0, 1);
    idle(6);
    n_chk++; if (mon_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d windows want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_chk++;
      if (mon_q[i] !== exp_q[i]) $display("FAIL b2b_win%0d: got data=%h sef=%b%b%b cyc=%0d want data=%h sef=%b%b%b cyc=%0d", i, mon_q[i].data, mon_q[i].sof, mon_q[i].eol, mon_q[i].eof, mon_q[i].cyc, exp_q[i].data, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_degenerate();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
